// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: fetch PC owner and dynamic-predictor controller.
// Tracks in-flight branch predictions, writes resolved outcomes back and redirects on mispredict.
`default_nettype none
module branch_predict_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_is_branch,
  input  logic [30:0] i_pred,
  input  logic        i_res_valid,
  input  logic        i_res_taken,
  input  logic [31:0] i_res_target,
  output logic [31:0] o_pc,
  output logic [9:0]  o_addrr,
  output logic        o_pred_taken,
  output logic [9:0]  o_addrw,
  output logic        o_we,
  output logic        o_next,
  output logic [29:0] o_wdata,
  output logic        o_flush,
  output logic        o_full,
  output logic        o_empty
);
  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, next_q, flush_q;
  logic [9:0]    addrw_q;
  logic [29:0]   wdata_q;

  logic [31:0]   q_pc_q  [DEPTH];
  logic          q_tk_q  [DEPTH];
  logic [29:0]   q_tgt_q [DEPTH];

  logic          push, pop, mispred, hold;
  logic [31:0]   head_pc;
  logic          head_tk;
  logic [29:0]   head_tgt;

  assign head_pc  = q_pc_q[head_q];
  assign head_tk  = q_tk_q[head_q];
  assign head_tgt = q_tgt_q[head_q];

  assign o_full       = (count_q == FULL_CNT);
  assign o_empty      = (count_q == '0);
  assign o_pc         = pc_q;
  assign o_addrr      = pc_q[11:2];
  assign o_pred_taken = i_is_branch & i_pred[0];
  assign o_we         = we_q;
  assign o_addrw      = addrw_q;
  assign o_next       = next_q;
  assign o_wdata      = wdata_q;
  assign o_flush      = flush_q;

  // A taken/taken pair still mispredicts when the predicted target differs.
  assign pop     = i_res_valid & ~o_empty;
  assign mispred = pop & ((head_tk != i_res_taken) |
                          (i_res_taken & (head_tgt != i_res_target[31:2])));
  assign push    = i_is_branch & ~i_stall & ~o_full & ~mispred;
  assign hold    = i_stall | (i_is_branch & o_full);

  always_comb begin
    pc_d    = pc_q + 32'd4;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispred) begin
      pc_d    = i_res_taken ? i_res_target : head_pc + 32'd4;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (hold)              pc_d = pc_q;
      else if (o_pred_taken) pc_d = {i_pred[30:1], 2'b00};
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Queue payload needs no reset; validity is carried by head/tail/count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[tail_q]  <= pc_q;
      q_tk_q[tail_q]  <= i_pred[0];
      q_tgt_q[tail_q] <= i_pred[30:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addrw_q <= '0;
      next_q  <= 1'b0;
      wdata_q <= '0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= pop;
      flush_q <= mispred;
      if (pop) begin
        addrw_q <= head_pc[11:2];
        next_q  <= i_res_taken;
        wdata_q <= i_res_target[31:2];
      end
    end
  end
endmodule
`default_nettype wire
